pcie_tlp_tx_arb: RTL

Transmit-side TLP arbiter that shares one link transmit datapath between NUMREQ TLP sources, e.g. completion, posted and non-posted queues of an endpoint or host model. It sits between the sources and the link-layer framer feeding the LinkOut lanes. Selection is round-robin. A grant is issued only if the link partner's advertised flow-control credits cover the TLP length. After a grant, the block muxes the winner's data stream onto the shared output until its last beat.

---
 rtl/pcie_tlp_tx_arb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pcie_tlp_tx_arb.sv
// pcie_tlp_tx_arb: round-robin, credit-gated TLP transmit arbiter.
// Shares one transmit datapath between NUMREQ sources; a grant is issued only
// when the advertised flow-control credits cover the TLP length.
// Optional macro PCIE_TLP_TX_ARB_STRICT_PRI0_EN: requester 0 (completions)
// wins whenever eligible and its grants leave the round-robin pointer alone.
module pcie_tlp_tx_arb #(
  parameter int unsigned NUMREQ = 4,
  parameter int unsigned DATAW  = 32,
  parameter int unsigned CREDW  = 12
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUMREQ-1:0]       Req,
  input  logic [NUMREQ*10-1:0]    Len,
  input  logic [NUMREQ-1:0]       InValid,
  input  logic [NUMREQ-1:0]       InLast,
  input  logic [NUMREQ*DATAW-1:0] InData,
  output logic [NUMREQ-1:0]       InReady,
  output logic [NUMREQ-1:0]       Gnt,
  output logic                    OutValid,
  output logic                    OutLast,
  output logic [DATAW-1:0]        OutData,
  input  logic                    OutReady,
  input  logic                    CreditLoad,
  input  logic [CREDW-1:0]        CreditLoadVal,
  input  logic                    CreditRet,
  input  logic [CREDW-1:0]        CreditRetVal,
  output logic [CREDW-1:0]        CreditAvail,
  output logic                    Busy
);

  localparam int unsigned PTRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;
  localparam int unsigned LENW = 11;
  localparam int unsigned CMPW = ((CREDW > LENW) ? CREDW : LENW) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_XFER} state_e;

  state_e            state_q, state_d;
  logic [NUMREQ-1:0] gnt_q, gnt_d;
  logic [PTRW-1:0]   gidx_q, gidx_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [CREDW-1:0]  cred_q, cred_d;
  logic              busy_q, busy_d;

  logic [LENW-1:0]   eff_len [NUMREQ];
  logic [NUMREQ-1:0] eligible;
  logic              win_found;
  logic [PTRW-1:0]   win_idx;
  logic              win_keeps_ptr;
  logic [CMPW-1:0]   debit;
  logic [CMPW-1:0]   cred_sum;

  // Effective length (0 encodes 1024) and credit eligibility per requester
  always_comb begin
    for (int unsigned i = 0; i < NUMREQ; i++) begin
      eff_len[i]  = (Len[i*10 +: 10] == 10'd0) ? LENW'(1024) : LENW'(Len[i*10 +: 10]);
      eligible[i] = Req[i] && (CMPW'(eff_len[i]) <= CMPW'(cred_q));
    end
  end

  // Winner search: first eligible requester from the pointer upward, wrapping
  always_comb begin
    int unsigned idx;
    idx           = 0;
    win_found     = 1'b0;
    win_idx       = '0;
    win_keeps_ptr = 1'b0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      idx = (32'(ptr_q) + k) % NUMREQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = PTRW'(idx);
      end
    end
`ifdef PCIE_TLP_TX_ARB_STRICT_PRI0_EN
    if (eligible[0]) begin
      win_found     = 1'b1;
      win_idx       = '0;
      win_keeps_ptr = 1'b1;
    end
`endif
  end

  // Shared output mux: pass-through of the granted requester while in XFER
  always_comb begin
    OutValid = 1'b0;
    OutLast  = 1'b0;
    OutData  = '0;
    InReady  = '0;
    if (state_q == ST_XFER) begin
      OutValid         = InValid[gidx_q];
      OutLast          = InLast[gidx_q];
      OutData          = InData[int'(gidx_q)*DATAW +: DATAW];
      InReady[gidx_q]  = OutReady;
    end
  end

  // Next-state, grant and pointer update
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    debit   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|Req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_found) begin
          gnt_d   = NUMREQ'(1) << win_idx;
          gidx_d  = win_idx;
          debit   = CMPW'(eff_len[win_idx]);
          state_d = ST_XFER;
          if (!win_keeps_ptr) begin
            ptr_d = (win_idx == PTRW'(NUMREQ-1)) ? '0 : win_idx + PTRW'(1);
          end
        end else if (!(|Req)) begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (OutValid && OutReady && OutLast) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_XFER);
  end

  // Credit counter: load overrides; otherwise net of return and debit, saturating
  always_comb begin
    cred_sum = CMPW'(cred_q) + (CreditRet ? CMPW'(CreditRetVal) : CMPW'(0)) - debit;
    if (CreditLoad) begin
      cred_d = CreditLoadVal;
    end else if (cred_sum > CMPW'({CREDW{1'b1}})) begin
      cred_d = {CREDW{1'b1}};
    end else begin
      cred_d = CREDW'(cred_sum);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cred_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      busy_q  <= busy_d;
    end
  end

  assign Gnt         = gnt_q;
  assign CreditAvail = cred_q;
  assign Busy        = busy_q;

endmodule
